// File: rtl/frog_pkg.sv
// rtl/frog_pkg.sv - shared state, winner codes and lamp patterns for the frog race controller
package frog_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COUNTDOWN = 2'd1,
    RACE      = 2'd2,
    WIN       = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    NONE = 2'b00,
    P1   = 2'b01,
    P2   = 2'b10,
    TIE  = 2'b11
  } winner_t;

  localparam logic [3:0] CD_LAMP_0  = 4'b1111;
  localparam logic [3:0] CD_LAMP_1  = 4'b0111;
  localparam logic [3:0] CD_LAMP_2  = 4'b0011;
  localparam logic [3:0] CD_LAMP_3  = 4'b0001;
  localparam logic [3:0] RACE_LAMP  = 4'b0001;
  localparam logic [3:0] BLINK_LAMP = 4'b1111;
  localparam logic [3:0] LAMP_OFF   = 4'b0000;

  function automatic logic [3:0] cd_lamp(input logic [1:0] step);
    logic [3:0] lamp;
    case (step)
      2'd0:    lamp = CD_LAMP_0;
      2'd1:    lamp = CD_LAMP_1;
      2'd2:    lamp = CD_LAMP_2;
      default: lamp = CD_LAMP_3;
    endcase
    return lamp;
  endfunction

endpackage

// File: rtl/frog_btn_edge.sv
// rtl/frog_btn_edge.sv - one-cycle registered rising-edge detector for a button level
module frog_btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic prev;

  // Previous sample starts high so a button held through reset gives no edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev <= 1'b1;
    else     prev <= din;
  end

  assign rise = din & ~prev;

endmodule

// File: rtl/frog_race_ctrl.sv
// rtl/frog_race_ctrl.sv - frog race sequencer; optional false-start detection via FROG_FALSE_START_EN
module frog_race_ctrl
  import frog_pkg::*;
#(
  parameter int LANE_LEN    = 9,
  parameter int TICK_CYCLES = 25_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  go_1,
  input  logic                  go_2,
  input  logic                  back_1,
  input  logic                  back_2,
  output logic [2*LANE_LEN-1:0] outview,
  output logic [3:0]            light_1,
  output logic [3:0]            light_2,
  output logic [1:0]            winner,
  output logic                  busy
);

  localparam int PW = $clog2(LANE_LEN);
  localparam int TW = $clog2(TICK_CYCLES);
  localparam logic [PW-1:0] GOAL      = PW'(LANE_LEN - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);

  logic start_e, go_1_e, go_2_e, back_1_e, back_2_e;

  frog_btn_edge u_start  (.clk(clk), .rst(rst), .din(start),  .rise(start_e));
  frog_btn_edge u_go_1   (.clk(clk), .rst(rst), .din(go_1),   .rise(go_1_e));
  frog_btn_edge u_go_2   (.clk(clk), .rst(rst), .din(go_2),   .rise(go_2_e));
  frog_btn_edge u_back_1 (.clk(clk), .rst(rst), .din(back_1), .rise(back_1_e));
  frog_btn_edge u_back_2 (.clk(clk), .rst(rst), .din(back_2), .rise(back_2_e));

  state_t        state, state_nx;
  winner_t       win_q, win_nx;
  logic [PW-1:0] pos_1, pos_2, pos_1_nx, pos_2_nx, mv_1, mv_2;
  logic [TW-1:0] tick, tick_nx;
  logic [1:0]    step, step_nx;
  logic          blink, blink_nx;
  logic          tick_wrap;

  function automatic logic [PW-1:0] move(input logic [PW-1:0] pos, input logic fwd, input logic bwd);
    if (fwd && !bwd) return pos + PW'(1);
    if (bwd && !fwd && pos != '0) return pos - PW'(1);
    return pos;
  endfunction

  assign tick_wrap = (tick == TICK_LAST);

  // State and datapath registers; reset puts both frogs on cell 0 in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      win_q <= NONE;
      pos_1 <= '0;
      pos_2 <= '0;
      tick  <= '0;
      step  <= '0;
      blink <= 1'b1;
    end else begin
      state <= state_nx;
      win_q <= win_nx;
      pos_1 <= pos_1_nx;
      pos_2 <= pos_2_nx;
      tick  <= tick_nx;
      step  <= step_nx;
      blink <= blink_nx;
    end
  end

  // Next-state logic; a start edge restarts the countdown from any state.
  always_comb begin
    state_nx = state;
    win_nx   = win_q;
    pos_1_nx = pos_1;
    pos_2_nx = pos_2;
    step_nx  = step;
    blink_nx = blink;
    tick_nx  = tick_wrap ? '0 : tick + TW'(1);
    mv_1     = move(pos_1, go_1_e, back_1_e);
    mv_2     = move(pos_2, go_2_e, back_2_e);
    if (start_e) begin
      state_nx = COUNTDOWN;
      win_nx   = NONE;
      pos_1_nx = '0;
      pos_2_nx = '0;
      tick_nx  = '0;
      step_nx  = '0;
    end else begin
      case (state)
        COUNTDOWN: begin
`ifdef FROG_FALSE_START_EN
          if (go_1_e || go_2_e) begin
            state_nx = WIN;
            win_nx   = winner_t'({go_1_e, go_2_e});
            tick_nx  = '0;
            blink_nx = 1'b1;
          end else
`endif
          if (tick_wrap) begin
            if (step == 2'd3) begin
              state_nx = RACE;
              tick_nx  = '0;
            end else begin
              step_nx = step + 2'd1;
            end
          end
        end
        RACE: begin
          pos_1_nx = mv_1;
          pos_2_nx = mv_2;
          if (mv_1 == GOAL || mv_2 == GOAL) begin
            state_nx = WIN;
            win_nx   = winner_t'({mv_2 == GOAL, mv_1 == GOAL});
            tick_nx  = '0;
            blink_nx = 1'b1;
          end
        end
        WIN: begin
          if (tick_wrap) blink_nx = ~blink;
        end
        default: ;
      endcase
    end
  end

  // Lamp drive from state: countdown steps, steady race lamp, winner blink.
  always_comb begin
    light_1 = LAMP_OFF;
    light_2 = LAMP_OFF;
    case (state)
      COUNTDOWN: begin
        light_1 = cd_lamp(step);
        light_2 = cd_lamp(step);
      end
      RACE: begin
        light_1 = RACE_LAMP;
        light_2 = RACE_LAMP;
      end
      WIN: begin
        if (blink && winner[0]) light_1 = BLINK_LAMP;
        if (blink && winner[1]) light_2 = BLINK_LAMP;
      end
      default: ;
    endcase
  end

  assign winner  = win_q;
  assign busy    = (state == COUNTDOWN) || (state == RACE);
  assign outview = {({{(LANE_LEN-1){1'b0}}, 1'b1} << pos_2),
                    ({{(LANE_LEN-1){1'b0}}, 1'b1} << pos_1)};

endmodule

// File: tb/tb_frog_race_ctrl.sv
// tb/tb_frog_race_ctrl.sv - scoreboard bench for frog_race_ctrl against a race-rules model
module tb_frog_race_ctrl;

  localparam int L = 9;
  localparam int T = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, go_1 = 1'b0, go_2 = 1'b0, back_1 = 1'b0, back_2 = 1'b0;
  logic [2*L-1:0] outview;
  logic [3:0] light_1, light_2;
  logic [1:0] winner;
  logic busy;

  frog_race_ctrl #(.LANE_LEN(L), .TICK_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .start(start), .go_1(go_1), .go_2(go_2),
    .back_1(back_1), .back_2(back_2), .outview(outview),
    .light_1(light_1), .light_2(light_2), .winner(winner), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2*L-1:0] ov;
    logic [3:0]     l1;
    logic [3:0]     l2;
    logic [1:0]     w;
    logic           b;
  } obs_t;

  obs_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: mode 0 idle, 1 countdown, 2 race, 3 win; m_t = cycles spent in mode.
  int         m_mode;
  int         m_pos[2];
  int         m_t;
  logic [1:0] m_win;
  logic [4:0] m_prev;

  function automatic void model_reset();
    m_mode = 0; m_pos[0] = 0; m_pos[1] = 0; m_t = 0; m_win = 2'b00; m_prev = 5'b11111;
  endfunction

  function automatic int clamp_move(input int p, input logic f, input logic b);
    int n;
    n = p + (f ? 1 : 0) - (b ? 1 : 0);
    return (n < 0) ? 0 : n;
  endfunction

  // in = {start, go_1, go_2, back_1, back_2}; models one rising clock edge.
  function automatic void model_step(input logic [4:0] in);
    logic [4:0] e;
    int n0, n1;
    e = in & ~m_prev;
    m_prev = in;
    if (e[4]) begin
      m_mode = 1; m_t = 0; m_pos[0] = 0; m_pos[1] = 0; m_win = 2'b00;
      return;
    end
    case (m_mode)
      1: begin
`ifdef FROG_FALSE_START_EN
        if (e[3] || e[2]) begin
          m_mode = 3; m_t = 0; m_win = {e[3], e[2]};
          return;
        end
`endif
        m_t++;
        if (m_t == 4 * T) begin m_mode = 2; m_t = 0; end
      end
      2: begin
        n0 = clamp_move(m_pos[0], e[3], e[1]);
        n1 = clamp_move(m_pos[1], e[2], e[0]);
        m_pos[0] = n0; m_pos[1] = n1;
        m_t++;
        if (n0 == L - 1 || n1 == L - 1) begin
          m_mode = 3; m_t = 0; m_win = {n1 == L - 1, n0 == L - 1};
        end
      end
      3: m_t++;
      default: ;
    endcase
  endfunction

  function automatic obs_t model_out();
    obs_t o;
    logic [3:0] full;
    full = 4'b1111;
    o = '0;
    o.ov[m_pos[0]] = 1'b1;
    o.ov[L + m_pos[1]] = 1'b1;
    o.w = m_win;
    o.b = (m_mode == 1) || (m_mode == 2);
    case (m_mode)
      1: begin o.l1 = full >> (m_t / T); o.l2 = full >> (m_t / T); end
      2: begin o.l1 = 4'b0001; o.l2 = 4'b0001; end
      3: if ((m_t / T) % 2 == 0) begin
        if (m_win[0]) o.l1 = 4'b1111;
        if (m_win[1]) o.l2 = 4'b1111;
      end
      default: ;
    endcase
    return o;
  endfunction

  task automatic compare(input obs_t a, input obs_t e, input string name);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s at %0t: got ov=%h l1=%b l2=%b w=%b busy=%b, expected ov=%h l1=%b l2=%b w=%b busy=%b",
               name, $time, a.ov, a.l1, a.l2, a.w, a.b, e.ov, e.l1, e.l2, e.w, e.b);
    end
  endtask

  function automatic obs_t dut_obs();
    return {outview, light_1, light_2, winner, busy};
  endfunction

  // Monitor: one expected observation is queued per clock edge; check it just after the edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) compare(dut_obs(), exp_q.pop_front(), "cycle");
    end
  end

  task automatic cyc(input logic [4:0] in);
    @(negedge clk);
    rst = 1'b0;
    {start, go_1, go_2, back_1, back_2} = in;
    model_step(in);
    exp_q.push_back(model_out());
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(5'b00000);
  endtask

  task automatic pulse(input logic [4:0] in);
    cyc(in);
    cyc(5'b00000);
  endtask

  task automatic do_rst(input logic [4:0] in);
    @(negedge clk);
    rst = 1'b1;
    {start, go_1, go_2, back_1, back_2} = in;
    model_reset();
    #1;
    compare(dut_obs(), model_out(), "async_reset");
    exp_q.push_back(model_out());
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  logic [4:0] cur;

  initial begin
    model_reset();
    // Reset with go_1 held high across release: no move edge.
    do_rst(5'b01000);
    repeat (3) cyc(5'b01000);
    idle(2);
    // Countdown and race entry.
    pulse(5'b10000);
    idle(18);
    // Player 1 walks to the goal; watch the blink.
    repeat (8) pulse(5'b01000);
    idle(12);
    // Go edge during countdown (false start or ignored).
    pulse(5'b10000);
    idle(2);
    pulse(5'b01000);
    idle(18);
    pulse(5'b10000);
    idle(18);
    // back at 0, go+back together, held go.
    pulse(5'b00001);
    pulse(5'b00101);
    repeat (10) cyc(5'b01000);
    idle(1);
    // Both to cell 7 then simultaneous finish.
    repeat (6) pulse(5'b01000);
    repeat (7) pulse(5'b00100);
    pulse(5'b01100);
    idle(10);
    // Reset mid-race at position 5.
    pulse(5'b10000);
    idle(17);
    repeat (5) pulse(5'b01000);
    do_rst(5'b00000);
    idle(3);
    // Start mid-race.
    pulse(5'b10000);
    idle(17);
    repeat (3) pulse(5'b01000);
    pulse(5'b10000);
    idle(5);
    // Randomized play.
    cur = 5'b00000;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 999) < 3) begin
        do_rst(cur);
      end else begin
        cur[4] = ($urandom_range(0, 99) < 2);
        if ($urandom_range(0, 99) < 40) cur[3] = ~cur[3];
        if ($urandom_range(0, 99) < 40) cur[2] = ~cur[2];
        if ($urandom_range(0, 99) < 15) cur[1] = ~cur[1];
        if ($urandom_range(0, 99) < 15) cur[0] = ~cur[0];
        cyc(cur);
      end
    end
    idle(2);
    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected observations left, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/frog_race_ctrl.md
# frog_race_ctrl

Game sequencer for the two-player frog race. It runs the start countdown, turns player button presses into lane moves, detects the finish (including ties) and drives the race display. It sits between the raw button inputs and the display/lamp outputs, in the same slot as the current top-level game (`outview`, `light_1`, `light_2`).

## Interface
Parameters:
- `LANE_LEN`, default 9: cells per lane; cell `LANE_LEN-1` is the goal; minimum 2.
- `TICK_CYCLES`, default 25_000_000: clock cycles per countdown step and per win-blink phase; minimum 2.

Ports:
- `clk` input 1: single clock, rising-edge.
- `rst` input 1: reset, asynchronous, active-high.
- `start` input 1: level; a rising edge starts or restarts a race.
- `go_1`, `go_2` input 1: level; a rising edge moves that frog forward one cell.
- `back_1`, `back_2` input 1: level; a rising edge moves that frog back one cell.
- `outview` output 2*LANE_LEN: `[LANE_LEN-1:0]` is lane 1, `[2*LANE_LEN-1:LANE_LEN]` is lane 2; each lane is one-hot on the frog position.
- `light_1`, `light_2` output 4: player lamps.
- `winner` output 2: 00 none, 01 player 1, 10 player 2, 11 tie.
- `busy` output 1: high in COUNTDOWN and RACE.

## Operation
- All button inputs are synchronous to `clk`. Edges are detected against a one-cycle registered copy. An input already high when reset releases does not produce an edge.
- States:
  - IDLE: positions at 0, lamps 0000. A `start` edge goes to COUNTDOWN.
  - COUNTDOWN: both lamps step 1111, 0111, 0011, 0001, each held TICK_CYCLES cycles, then the block enters RACE with positions at 0. Move edges are ignored, unless the false-start feature is compiled in (see Configuration).
  - RACE: both lamps 0001.
    - A go edge increments the position. A back edge decrements it, saturating at 0.
    - go and back edges from the same player in the same cycle: no move.
    - Both players act independently in the same cycle, with no priority.
    - If a new position equals LANE_LEN-1, the block enters WIN on that same edge.
    - If both players reach the goal on the same edge, `winner`=11.
  - WIN: positions frozen.
    - The winner's lamp toggles between 1111 and 0000 every TICK_CYCLES cycles, starting at 1111. On a tie both lamps blink.
    - The loser's lamp is 0000.
    - Move edges are ignored. A `start` edge goes to COUNTDOWN.
- A `start` edge in COUNTDOWN or RACE restarts COUNTDOWN from 1111 with positions at 0 and `winner`=00.
- `winner` is cleared on entry to COUNTDOWN.

## Timing
- Reset values: state IDLE, `outview` = bit 0 and bit LANE_LEN set, `light_1`/`light_2` 0000, `winner` 00, `busy` 0, tick counter 0.
- Reset asserted mid-race returns everything to the reset values immediately (asynchronous), with no pending move retained.
- Move latency: input sampled low at edge k-1 and high at edge k → `outview` updated after edge k. State, `winner`, lamps and `busy` update on that same edge k.
- Holding a button high gives exactly one move. A new move needs a low sample followed by a high sample.
- Tick counter: counts 0..TICK_CYCLES-1 and wraps. It resets to 0 on every state entry.
- Countdown length: exactly 4*TICK_CYCLES cycles from the `start` edge to RACE entry.

## Configuration
- `FROG_FALSE_START_EN`, defined:
  - A go edge during COUNTDOWN is a false start. The other player wins immediately (WIN, `winner` 10 or 01).
  - Both players false-starting on the same edge gives `winner`=11.
- `FROG_FALSE_START_EN`, undefined: all move edges during COUNTDOWN are ignored.

## Structure
- Package `frog_pkg`:
  - state enum (IDLE, COUNTDOWN, RACE, WIN)
  - winner codes (NONE, P1, P2, TIE)
  - countdown lamp pattern constants, RACE lamp constant 0001, blink constant 1111
- Sub-module `frog_btn_edge`: one-cycle registered rising-edge detector, with an asynchronous active-high reset that clears it to 1. This gives the no-edge-after-reset behaviour. Instantiate it once per button (5 instances).

## Test plan
All scenarios use LANE_LEN=9 and TICK_CYCLES=4.
- Reset, then `start` pulse → lamps 1111/0111/0011/0001 for 4 cycles each, RACE after 16 cycles, `busy`=1, `outview`=18'h00201.
- In RACE, 8 separate go_1 pulses → `outview[8:0]` walks to 9'h100, WIN on the 8th edge, `winner`=01, `light_1` blinks 1111/0000 every 4 cycles, `light_2`=0000.
- back_2 edge at position 0 → no change. go_2 and back_2 edges in the same cycle → no move. go_1 held high for 10 cycles → exactly one move.
- Both frogs at cell 7, go_1 and go_2 edges on the same cycle → `winner`=11, both lamps blink.
- go_1 edge during COUNTDOWN:
  - with `FROG_FALSE_START_EN`: WIN, `winner`=10.
  - without it: ignored, and RACE starts at position 0.
- `rst` pulsed mid-race at position 5, and separately `start` pulsed mid-race → reset values immediately for the former, and COUNTDOWN with `winner`=00 and positions 0 for the latter.
